bram_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 32-bit port of the 512x32 dual-port block RAM wrapper between NUM_REQ requesters, for example the DMA writer, the blitter and the framebuffer fetch. It issues at most one RAM access per cycle and acks the winning requester. For reads, it returns the RAM data one cycle later with a one-hot valid. Optional lock lets one requester own the port for a bounded burst.

---
 rtl/bram_rr_arbiter_pkg.sv | 15 +
 rtl/bram_rr_arbiter_rr_pick.sv | 33 +++
 rtl/bram_rr_arbiter.sv | 170 +++++++++++++++++
 tb/tb_bram_rr_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_rr_arbiter_pkg.sv
// Shared constants and helpers for the block-RAM round-robin arbiter.
package bram_rr_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic [0:0] ST_IDLE_RR = 1'b0;
    localparam logic [0:0] ST_LOCKED  = 1'b1;

    // Successor of index i in a ring of n requesters.
    function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/bram_rr_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first asserted request at or after ptr_in.
module rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N-1:0]     req_in,
    input  logic [PTR_W-1:0] ptr_in,
    output logic [N-1:0]     grant_out,
    output logic [PTR_W-1:0] idx_out,
    output logic             valid_out
);

    int unsigned j;

    always_comb begin
        grant_out = '0;
        idx_out   = '0;
        valid_out = 1'b0;
        j         = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = 32'(ptr_in) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!valid_out && req_in[j]) begin
                valid_out    = 1'b1;
                grant_out[j] = 1'b1;
                idx_out      = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter sharing one 32-bit block-RAM port between NUM_REQ requesters,
// with bounded lock bursts. Optional grant statistics under `BRAM_ARB_STATS_EN.
module bram_rr_arbiter
    import bram_rr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic [NUM_REQ-1:0]       req_in,
    input  logic [NUM_REQ-1:0]       lock_in,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
    input  logic [NUM_REQ*BE_W-1:0]  we_in,
    input  logic [NUM_REQ*DATA_W-1:0] wr_d_in,
    output logic [NUM_REQ-1:0]       ack_out,
    output logic [NUM_REQ-1:0]       rd_valid_out,
    output logic [DATA_W-1:0]        rd_d_out,
    output logic                     bram_en_out,
    output logic [BE_W-1:0]          bram_we_out,
    output logic [ADDR_W-1:0]        bram_addr_out,
    output logic [DATA_W-1:0]        bram_wr_d_out,
`ifdef BRAM_ARB_STATS_EN
    input  logic [2:0]               stat_sel_in,
    output logic [15:0]              stat_cnt_out,
`endif
    input  logic [DATA_W-1:0]        bram_rd_d_in
);

    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    logic [0:0]         state_q, state_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] rd_valid_q, rd_valid_d;

    logic [NUM_REQ-1:0] owner_mask;
    logic [NUM_REQ-1:0] req_eff;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   gnt_idx;
    logic               gnt_valid;
    logic [PTR_W-1:0]   owner_next;

    // While locked only the owner competes; reset masks every request.
    always_comb begin
        owner_mask = '1;
        if (state_q == ST_LOCKED) begin
            owner_mask          = '0;
            owner_mask[owner_q] = 1'b1;
        end
        req_eff = rst_n_in ? (req_in & owner_mask) : '0;
    end

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_in    (req_eff),
        .ptr_in    (ptr_q),
        .grant_out (grant),
        .idx_out   (gnt_idx),
        .valid_out (gnt_valid)
    );

    always_comb begin
        ack_out       = grant;
        bram_en_out   = gnt_valid;
        bram_we_out   = '0;
        bram_addr_out = '0;
        bram_wr_d_out = '0;
        if (gnt_valid) begin
            bram_we_out   = we_in[gnt_idx*BE_W +: BE_W];
            bram_addr_out = addr_in[gnt_idx*ADDR_W +: ADDR_W];
            bram_wr_d_out = wr_d_in[gnt_idx*DATA_W +: DATA_W];
        end
    end

    assign rd_d_out     = bram_rd_d_in;
    assign rd_valid_out = rd_valid_q;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        hold_d     = hold_q;
        ptr_d      = ptr_q;
        owner_next = PTR_W'(wrap_inc(32'(owner_q), NUM_REQ));
        rd_valid_d = (bram_we_out == '0) ? grant : '0;

        if (state_q == ST_IDLE_RR) begin
            if (gnt_valid) begin
                ptr_d = PTR_W'(wrap_inc(32'(gnt_idx), NUM_REQ));
                if (lock_in[gnt_idx]) begin
                    state_d = ST_LOCKED;
                    owner_d = gnt_idx;
                    hold_d  = HOLD_W'(1);
                end
            end
        end else begin
            // Owner leaving or burst limit reached both hand the port back to the ring.
            if (!req_in[owner_q]) begin
                state_d = ST_IDLE_RR;
                hold_d  = '0;
                ptr_d   = owner_next;
            end else if (gnt_valid) begin
                if (lock_in[owner_q] && (hold_q < HOLD_W'(MAX_HOLD - 1))) begin
                    hold_d = hold_q + HOLD_W'(1);
                end else begin
                    state_d = ST_IDLE_RR;
                    hold_d  = '0;
                    ptr_d   = owner_next;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= ST_IDLE_RR;
            owner_q    <= '0;
            hold_q     <= '0;
            ptr_q      <= '0;
            rd_valid_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            hold_q     <= hold_d;
            ptr_q      <= ptr_d;
            rd_valid_q <= rd_valid_d;
        end
    end

`ifdef BRAM_ARB_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];
    logic [15:0] cnt_d [NUM_REQ];
    logic [15:0] stat_cnt_q, stat_cnt_d;

    always_comb begin
        stat_cnt_d = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (grant[i] && (cnt_q[i] != 16'hFFFF)) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
            if (stat_sel_in == 3'(i)) begin
                stat_cnt_d = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
            stat_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stat_cnt_q <= stat_cnt_d;
        end
    end

    assign stat_cnt_out = stat_cnt_q;
`endif

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Self-checking bench for bram_rr_arbiter: directed scenarios plus randomized traffic
// compared each cycle against a transaction-level model of the arbiter and RAM.
module tb_bram_rr_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 9;
    localparam int MAXH = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req, lock;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*4-1:0]  we;
    logic [NREQ*32-1:0] wd;
    logic [NREQ-1:0]    ack, rd_valid;
    logic [31:0]        rd_d;
    logic               b_en;
    logic [3:0]         b_we;
    logic [AW-1:0]      b_addr;
    logic [31:0]        b_wd, b_rd;
`ifdef BRAM_ARB_STATS_EN
    logic [2:0]         stat_sel = 3'd0;
    logic [15:0]        stat_cnt;
`endif

    always #5 clk = ~clk;

    bram_rr_arbiter #(.NUM_REQ(NREQ), .ADDR_W(AW), .MAX_HOLD(MAXH)) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .req_in        (req),
        .lock_in       (lock),
        .addr_in       (addr),
        .we_in         (we),
        .wr_d_in       (wd),
        .ack_out       (ack),
        .rd_valid_out  (rd_valid),
        .rd_d_out      (rd_d),
        .bram_en_out   (b_en),
        .bram_we_out   (b_we),
        .bram_addr_out (b_addr),
        .bram_wr_d_out (b_wd),
`ifdef BRAM_ARB_STATS_EN
        .stat_sel_in   (stat_sel),
        .stat_cnt_out  (stat_cnt),
`endif
        .bram_rd_d_in  (b_rd)
    );

    // RAM attached to the arbitrated port, with a preload path used only during reset.
    logic [31:0] ram [512];
    logic        pl_en = 1'b0;
    logic [8:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    logic [31:0] ram_q = '0;
    assign b_rd = ram_q;

    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (b_en) begin
            for (int b = 0; b < 4; b++)
                if (b_we[b]) ram[b_addr][8*b +: 8] <= b_wd[8*b +: 8];
            ram_q <= ram[b_addr];
        end
    end

    // Requester drive state.
    logic        d_req  [NREQ];
    logic        d_lock [NREQ];
    logic [8:0]  d_addr [NREQ];
    logic [3:0]  d_we   [NREQ];
    logic [31:0] d_wd   [NREQ];

    // Model state.
    logic [31:0] shadow [512];
    int          m_ptr, m_owner, m_burst, exp_rv;
    bit          m_locked;
    logic [31:0] exp_data;

    int total = 0;
    int bad   = 0;
    logic [NREQ-1:0] last_ack, last_rv;
    logic [31:0]     last_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_locked = 0; m_owner = 0; m_burst = 0; exp_rv = -1;
    endtask

    task automatic clear_drive();
        for (int i = 0; i < NREQ; i++) begin
            d_req[i] = 0; d_lock[i] = 0; d_addr[i] = '0; d_we[i] = '0; d_wd[i] = '0;
        end
    endtask

    // One clock: drive at negedge, compare against model, advance model at posedge.
    task automatic cycle();
        int g;
        logic [3:0] eg;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            req[i] = d_req[i]; lock[i] = d_lock[i];
            addr[i*AW +: AW] = d_addr[i]; we[i*4 +: 4] = d_we[i]; wd[i*32 +: 32] = d_wd[i];
        end
        #1;
        g = -1;
        if (rst_n) begin
            if (m_locked) begin
                if (d_req[m_owner]) g = m_owner;
            end else begin
                for (int k = 0; k < NREQ; k++)
                    if (g < 0 && d_req[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
        end
        eg = (g >= 0) ? 4'(1 << g) : 4'b0;
        last_ack = ack; last_rv = rd_valid; last_rd = rd_d;
        chk("ack", 32'(ack), 32'(eg));
        chk("bram_en", 32'(b_en), 32'(g >= 0));
        chk("bram_addr", 32'(b_addr), (g >= 0) ? 32'(d_addr[g]) : 32'd0);
        chk("bram_we", 32'(b_we), (g >= 0) ? 32'(d_we[g]) : 32'd0);
        chk("bram_wr_d", b_wd, (g >= 0) ? d_wd[g] : 32'd0);
        chk("rd_valid", 32'(rd_valid), (exp_rv >= 0) ? 32'(1 << exp_rv) : 32'd0);
        if (exp_rv >= 0) chk("rd_d", rd_d, exp_data);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            exp_rv = -1;
            if (g >= 0) begin
                if (d_we[g] == 4'b0) begin
                    exp_rv = g; exp_data = shadow[d_addr[g]];
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (d_we[g][b]) shadow[d_addr[g]][8*b +: 8] = d_wd[g][8*b +: 8];
                end
            end
            if (m_locked) begin
                if (g < 0) begin
                    m_locked = 0; m_ptr = (m_owner + 1) % NREQ;
                end else begin
                    m_burst++;
                    if (!d_lock[g] || m_burst >= MAXH) begin
                        m_locked = 0; m_ptr = (m_owner + 1) % NREQ;
                    end
                end
            end else if (g >= 0) begin
                m_ptr = (g + 1) % NREQ;
                if (d_lock[g]) begin m_locked = 1; m_owner = g; m_burst = 1; end
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) begin
            cycle();
            chk("ack_in_reset", 32'(last_ack), 32'd0);
        end
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int n2;
        bit saw3;
        clear_drive();
        req = '0; lock = '0; addr = '0; we = '0; wd = '0;
        model_reset();

        // Preload RAM and shadow while held in reset.
        for (int a = 0; a < 512; a++) begin
            @(negedge clk);
            pl_en = 1'b1; pl_addr = 9'(a);
            pl_data = (a == 5) ? 32'hDEADBEEF : (a == 16) ? 32'hAABBCCDD : 32'(a) * 32'h9E3779B1;
            shadow[a] = pl_data;
        end
        @(negedge clk) pl_en = 1'b0;

        // Reset with all requesting, then rotation from requester 0.
        for (int i = 0; i < NREQ; i++) d_req[i] = 1;
        do_reset();
        cycle(); chk("rot0", 32'(last_ack), 32'h1);
        cycle(); chk("rot1", 32'(last_ack), 32'h2);
        cycle(); chk("rot2", 32'(last_ack), 32'h4);
        cycle(); chk("rot3", 32'(last_ack), 32'h8);
        cycle(); chk("rot4", 32'(last_ack), 32'h1);

        // Single read by requester 0.
        clear_drive(); do_reset();
        d_req[0] = 1; d_addr[0] = 9'h005;
        cycle(); chk("rd_ack", 32'(last_ack), 32'h1);
        d_req[0] = 0;
        cycle(); chk("rd_valid_lit", 32'(last_rv), 32'h1); chk("rd_data_lit", last_rd, 32'hDEADBEEF);

        // Partial write then read back.
        d_req[1] = 1; d_addr[1] = 9'h010; d_we[1] = 4'b0011; d_wd[1] = 32'h12345678;
        cycle(); chk("wr_ack", 32'(last_ack), 32'h2);
        d_we[1] = 4'b0000; d_wd[1] = '0;
        cycle(); chk("wr_no_valid", 32'(last_rv), 32'h0); chk("rb_ack", 32'(last_ack), 32'h2);
        d_req[1] = 0;
        cycle(); chk("rb_valid", 32'(last_rv), 32'h2); chk("rb_data", last_rd, 32'hAABB5678);

        // Locked burst by requester 2 while 3 waits.
        clear_drive(); do_reset();
        d_req[2] = 1; d_lock[2] = 1; d_addr[2] = 9'h020;
        d_req[3] = 1; d_addr[3] = 9'h030;
        n2 = 0; saw3 = 0;
        for (int c = 0; c < 40 && !saw3; c++) begin
            cycle();
            if (last_ack == 4'b0100) n2++;
            else if (last_ack == 4'b1000) saw3 = 1;
        end
        chk("lock_burst_len", 32'(n2), 32'd16);
        chk("lock_then_req3", 32'(saw3), 32'd1);

        // Requester 1 drops mid-burst.
        clear_drive(); do_reset();
        d_req[1] = 1; d_lock[1] = 1; d_addr[1] = 9'h001;
        cycle(); chk("lk1_first", 32'(last_ack), 32'h2);
        d_req[0] = 1; d_req[2] = 1; d_addr[2] = 9'h002;
        cycle(); chk("lk1_hold_a", 32'(last_ack), 32'h2);
        cycle(); chk("lk1_hold_b", 32'(last_ack), 32'h2);
        d_req[1] = 0;
        cycle(); chk("lk1_drop", 32'(last_ack), 32'h0);
        cycle(); chk("lk1_next", 32'(last_ack), 32'h4);

        // Asynchronous reset while a read is returning.
        clear_drive(); do_reset();
        d_req[0] = 1; d_addr[0] = 9'h005;
        cycle();
        d_req[0] = 0;
        #2 chk("pre_rst_valid", 32'(rd_valid), 32'h1);
        rst_n = 1'b0; model_reset();
        #1 chk("async_clear", 32'(rd_valid), 32'h0);
        repeat (2) cycle();
        chk("rst_hold_valid", 32'(last_rv), 32'h0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) d_req[i] = 1;
        cycle(); chk("post_rst_ptr0", 32'(last_ack), 32'h1);

        // Randomized traffic with handshake-obeying requesters.
        clear_drive(); do_reset();
        for (int c = 0; c < 3000; c++) begin
            cycle();
            for (int i = 0; i < NREQ; i++) begin
                if ((d_req[i] && last_ack[i]) || !d_req[i]) begin
                    if ($urandom_range(0, 9) < (d_req[i] ? 6 : 4)) begin
                        d_req[i]  = 1;
                        d_lock[i] = ($urandom_range(0, 5) == 0);
                        d_addr[i] = 9'($urandom_range(0, 23));
                        d_we[i]   = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
                        d_wd[i]   = $urandom;
                    end else begin
                        d_req[i] = 0; d_lock[i] = 0;
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
